wb_write_queue: RTL

Writeback-side writer for the 32x32 register file in the pipeline. It accepts completed results from the MEM/WB boundary through a valid/ready handshake and selects ALU result or load data per entry. It buffers up to DEPTH pending writes and drives the register file write port (`rd`, `writedata`, `regwrite`) at one write per cycle. It also gives the ID stage a bypass lookup, so reads of `rs`/`rt` see the newest pending value before it lands in the register file.

---
 rtl/pipe_pkg.sv | 16 +
 rtl/wb_fifo.sv | 82 ++++++++
 rtl/wb_write_queue.sv | 107 ++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: datapath widths, the hardwired-zero register
// index and the pending-write entry layout used by the writeback queue.
package pipe_pkg;

  localparam int DW = 32;
  localparam int AW = 5;

  // Register 0 is hardwired to zero: never written, never forwarded.
  localparam logic [AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of pending register-file writes. Besides the usual
// push/pop/head interface it exposes every storage slot together with a
// per-slot occupancy vector and the index of the most recently pushed slot,
// so the owner can search the pending writes for forwarding.
module wb_fifo
  import pipe_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push_i,
  input  wb_entry_t                     entry_i,
  input  logic                          pop_i,
  output logic                          full_o,
  output logic                          empty_o,
  output wb_entry_t                     head_o,
  output wb_entry_t [DEPTH-1:0]         entries_o,
  output logic [DEPTH-1:0]              valid_o,
  output logic [$clog2(DEPTH)-1:0]      newest_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_entry_t [DEPTH-1:0] mem_q;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

  // A push into a full FIFO only lands when a pop frees the slot that edge;
  // a pop on an empty FIFO is ignored, so count stays within 0..DEPTH.
  assign push_ok = push_i && (!full_o || pop_i);
  assign pop_ok  = pop_i && !empty_o;

  // Next pointers and occupancy; pointers wrap naturally modulo DEPTH.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
    count_d = count_q + CW'(push_ok) - CW'(pop_ok);
  end

  // Control state; reset discards every pending entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are qualified by valid_o, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= entry_i;
  end

  // A slot is occupied when its distance from the head is below the count.
  always_comb begin
    logic [PW-1:0] offset;
    valid_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset     = PW'(i) - rd_ptr_q;
      valid_o[i] = ({1'b0, offset} < count_q);
    end
  end

  assign head_o    = mem_q[rd_ptr_q];
  assign entries_o = mem_q;
  assign newest_o  = wr_ptr_q - PW'(1);

endmodule

// File: rtl/wb_write_queue.sv
// Writeback-side register-file writer: accepts MEM/WB results, resolves the
// ALU/load mux at enqueue, buffers up to DEPTH pending writes, drains one per
// cycle into the register file and offers a youngest-match bypass for rs/rt.
module wb_write_queue
  import pipe_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int DW    = pipe_pkg::DW,
  parameter int AW    = pipe_pkg::AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_regwrite,
  input  logic          in_memtoreg,
  input  logic [AW-1:0] in_rd,
  input  logic [DW-1:0] in_aluresult,
  input  logic [DW-1:0] in_memdata,
  input  logic          hold,
  output logic [AW-1:0] rd,
  output logic [DW-1:0] writedata,
  output logic          regwrite,
  input  logic [AW-1:0] rs,
  input  logic [AW-1:0] rt,
  output logic          fwd_a_hit,
  output logic          fwd_b_hit,
  output logic [DW-1:0] fwd_a,
  output logic [DW-1:0] fwd_b,
  output logic          full,
  output logic          empty
);

  localparam int PW = $clog2(DEPTH);

  wb_entry_t             new_entry;
  wb_entry_t             head;
  wb_entry_t [DEPTH-1:0] entries;
  logic [DEPTH-1:0]      valid;
  logic [PW-1:0]         newest;
  logic                  keep;
  logic                  push;
  logic [DW:0]           srch_a, srch_b;

  // Youngest pending write to idx, returned as {hit, data}. Slots are visited
  // oldest to newest so a younger match overwrites an older one.
  function automatic logic [DW:0] fwd_search(
    input logic [AW-1:0]         idx,
    input wb_entry_t [DEPTH-1:0] ents,
    input logic [DEPTH-1:0]      vld,
    input logic [PW-1:0]         nw
  );
    logic [DW:0]   res;
    logic [PW-1:0] pos;
    res = '0;
    if (idx != REG_ZERO) begin
      for (int k = DEPTH - 1; k >= 0; k--) begin
        pos = nw - PW'(k);
        if (vld[pos] && (ents[pos].rd == idx)) res = {1'b1, ents[pos].data};
      end
    end
    return res;
  endfunction

  // Writes to r0 or without regwrite are accepted but never stored.
  assign keep = in_regwrite && (in_rd != REG_ZERO);
  assign push = in_valid && in_ready && keep;

  // Load/ALU selection is frozen into the entry when it is enqueued.
  always_comb begin
    new_entry      = '0;
    new_entry.rd   = in_rd;
    new_entry.data = in_memtoreg ? in_memdata : in_aluresult;
  end

  assign regwrite = !empty && !hold;
  assign in_ready = !full || regwrite;
  assign rd        = empty ? '0 : head.rd;
  assign writedata = empty ? '0 : head.data;

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_i    (push),
    .entry_i   (new_entry),
    .pop_i     (regwrite),
    .full_o    (full),
    .empty_o   (empty),
    .head_o    (head),
    .entries_o (entries),
    .valid_o   (valid),
    .newest_o  (newest)
  );

  // Bypass lookups see registered entries only, including the head draining now.
  always_comb begin
    srch_a    = fwd_search(rs, entries, valid, newest);
    srch_b    = fwd_search(rt, entries, valid, newest);
    fwd_a_hit = srch_a[DW];
    fwd_a     = srch_a[DW-1:0];
    fwd_b_hit = srch_b[DW];
    fwd_b     = srch_b[DW-1:0];
  end

endmodule
